shift_register_burst: RTL and testbench

- Parametrised successor to the team's 8-bit universal shift register.
- Generalises the width to W and adds rotate, arithmetic shift-right and synchronous clear modes, plus a clock-enable.
- Adds a burst engine that, from a single start pulse, repeats a latched operation for N cycles and reports with a busy/done handshake.
- Sits in the lab datapath as the serial/parallel converter and barrel-like shifter driven by the control FSM.

---
 rtl/shift_reg_pkg.sv | 20 ++
 rtl/shift_burst_ctrl.sv | 64 ++++++
 rtl/shift_register_burst.sv | 75 +++++++
 tb/tb_shift_register_burst.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared encodings for the burst-capable shift register: datapath operation
// codes and the burst controller states.
package shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_burst_ctrl.sv
// Burst controller: accepts a start pulse, repeats the latched operation for
// the requested number of enabled cycles and flags completion for one cycle.
module shift_burst_ctrl
  import shift_reg_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          cp,
  input  logic          cr,
  input  logic          en,
  input  logic          start,
  input  logic [CW-1:0] cnt,
  input  logic [2:0]    mode,
  output logic          busy,
  output logic          done,
  output logic [2:0]    op_sel,
  output logic          op_valid
);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] rem;
  logic [2:0]    op_lat;

  // State, remaining count and latched operation; all frozen while en is low.
  always_ff @(posedge cp or posedge cr) begin
    if (cr) begin
      state  <= ST_IDLE;
      rem    <= '0;
      op_lat <= MODE_HOLD;
    end else if (en) begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        rem    <= cnt;
        op_lat <= mode;
      end else if (state == ST_RUN) begin
        rem <= rem - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (cnt != '0) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        if (rem == CW'(1)) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The accepting edge of a start leaves q untouched; DONE acts like IDLE for mode.
  always_comb begin
    busy     = (state == ST_RUN);
    done     = (state == ST_DONE);
    op_sel   = busy ? op_lat : mode;
    op_valid = en && !(state == ST_IDLE && start);
  end

endmodule

// File: rtl/shift_register_burst.sv
// W-bit universal shift register with rotate, arithmetic shift and clear modes,
// plus a burst engine that repeats one operation for N cycles.
module shift_register_burst
  import shift_reg_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          cp,
  input  logic          cr,
  input  logic          en,
  input  logic [2:0]    mode,
  input  logic          sr,
  input  logic          sl,
  input  logic [W-1:0]  d,
  input  logic          start,
  input  logic [CW-1:0] cnt,
  output logic [W-1:0]  q,
  output logic          so_r,
  output logic          so_l,
  output logic          busy,
  output logic          done
);

  logic [2:0]   op_sel;
  logic         op_valid;
  logic         accept;
  logic [W-1:0] d_lat;
  logic [W-1:0] q_nxt;

  shift_burst_ctrl #(.CW(CW)) u_ctrl (
    .cp       (cp),
    .cr       (cr),
    .en       (en),
    .start    (start),
    .cnt      (cnt),
    .mode     (mode),
    .busy     (busy),
    .done     (done),
    .op_sel   (op_sel),
    .op_valid (op_valid)
  );

  assign accept = en && start && !busy && !done;

  // A burst LOAD repeats the data captured with the start pulse, not live d.
  always_comb begin
    q_nxt = q;
    case (op_sel)
      MODE_HOLD: q_nxt = q;
      MODE_SHR:  q_nxt = {sr, q[W-1:1]};
      MODE_SHL:  q_nxt = {q[W-2:0], sl};
      MODE_LOAD: q_nxt = busy ? d_lat : d;
      MODE_ROR:  q_nxt = {q[0], q[W-1:1]};
      MODE_ROL:  q_nxt = {q[W-2:0], q[W-1]};
      MODE_ASR:  q_nxt = {q[W-1], q[W-1:1]};
      MODE_CLR:  q_nxt = '0;
      default:   q_nxt = q;
    endcase
  end

  always_ff @(posedge cp or posedge cr) begin
    if (cr) begin
      q     <= '0;
      d_lat <= '0;
    end else begin
      if (op_valid) q <= q_nxt;
      if (accept) d_lat <= d;
    end
  end

  assign so_r = q[0];
  assign so_l = q[W-1];

endmodule

// File: tb/tb_shift_register_burst.sv
// Scoreboard bench for shift_register_burst: a driver pushes model predictions
// per edge, a monitor pops and compares them after each rising edge.
module tb_shift_register_burst;
  import shift_reg_pkg::*;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          cp = 1'b0;
  logic          cr = 1'b1;
  logic          en = 1'b0;
  logic [2:0]    mode = MODE_HOLD;
  logic          sr = 1'b0;
  logic          sl = 1'b0;
  logic [W-1:0]  d = '0;
  logic          start = 1'b0;
  logic [CW-1:0] cnt = '0;
  logic [W-1:0]  q;
  logic          so_r;
  logic          so_l;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
  } expect_t;

  expect_t exp_q[$];

  // Reference model: plain counters describing how much burst work is left.
  logic [W-1:0] m_q = '0;
  int           m_left = 0;
  logic [2:0]   m_op = MODE_HOLD;
  logic [W-1:0] m_d = '0;
  logic         m_done = 1'b0;

  shift_register_burst #(.W(W), .CW(CW)) dut (
    .cp    (cp),
    .cr    (cr),
    .en    (en),
    .mode  (mode),
    .sr    (sr),
    .sl    (sl),
    .d     (d),
    .start (start),
    .cnt   (cnt),
    .q     (q),
    .so_r  (so_r),
    .so_l  (so_l),
    .busy  (busy),
    .done  (done)
  );

  always #5 cp = ~cp;

  function automatic logic [W-1:0] apply_op(input logic [2:0] op, input logic [W-1:0] qv,
                                            input logic s_r, input logic s_l,
                                            input logic [W-1:0] dv);
    logic [W-1:0] msb;
    msb = {1'b1, {(W-1){1'b0}}};
    case (op)
      MODE_SHR:  return (qv >> 1) | (s_r ? msb : '0);
      MODE_SHL:  return (qv << 1) | W'(s_l);
      MODE_LOAD: return dv;
      MODE_ROR:  return (qv >> 1) | (qv[0] ? msb : '0);
      MODE_ROL:  return (qv << 1) | W'(qv[W-1]);
      MODE_ASR:  return W'($signed(qv) >>> 1);
      MODE_CLR:  return '0;
      default:   return qv;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, required, $time);
    end
  endtask

  task automatic model_reset();
    m_q = '0;
    m_left = 0;
    m_op = MODE_HOLD;
    m_d = '0;
    m_done = 1'b0;
  endtask

  // Drives one cycle of inputs at the falling edge and predicts the next edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [2:0] m,
                               input logic s_r, input logic s_l, input logic [W-1:0] dv,
                               input logic st, input logic [CW-1:0] c);
    expect_t x;
    @(negedge cp);
    if (r) begin
      cr = 1'b1;
      #1;
      checkOutput("async_reset_q", 32'(q), 32'h0);
      checkOutput("async_reset_busy", 32'(busy), 32'h0);
      checkOutput("async_reset_done", 32'(done), 32'h0);
      model_reset();
      #1;
      cr = 1'b0;
    end
    en = e; mode = m; sr = s_r; sl = s_l; d = dv; start = st; cnt = c;
    if (e) begin
      if (m_left > 0) begin
        m_q = apply_op(m_op, m_q, s_r, s_l, m_d);
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end else if (m_done) begin
        m_q = apply_op(m, m_q, s_r, s_l, dv);
        m_done = 1'b0;
      end else if (st) begin
        m_op = m;
        m_d = dv;
        if (c == '0) m_done = 1'b1;
        else m_left = int'(c);
      end else begin
        m_q = apply_op(m, m_q, s_r, s_l, dv);
      end
    end
    x.q = m_q;
    x.busy = (m_left > 0);
    x.done = m_done;
    exp_q.push_back(x);
  endtask

  task automatic step(input logic [2:0] m, input logic [W-1:0] dv);
    applyStimulus(1'b0, 1'b1, m, 1'b0, 1'b0, dv, 1'b0, '0);
  endtask

  task automatic expect_const(input string name, input logic [W-1:0] val);
    @(posedge cp);
    #1;
    checkOutput(name, 32'(q), 32'(val));
  endtask

  // Monitor: compares every predicted edge against the DUT.
  initial begin
    expect_t x;
    forever begin
      @(posedge cp);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checkOutput("q", 32'(q), 32'(x.q));
        checkOutput("so_r", 32'(so_r), 32'(x.q[0]));
        checkOutput("so_l", 32'(so_l), 32'(x.q[W-1]));
        checkOutput("busy", 32'(busy), 32'(x.busy));
        checkOutput("done", 32'(done), 32'(x.done));
      end
    end
  end

  initial begin
    int guard;
    repeat (2) @(negedge cp);
    #1;
    checkOutput("por_q", 32'(q), 32'h0);
    checkOutput("por_busy", 32'(busy), 32'h0);
    cr = 1'b0;

    step(MODE_LOAD, 8'hFF);
    applyStimulus(1'b1, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hA5, 1'b0, '0);
    expect_const("load_a5", 8'hA5);
    applyStimulus(1'b0, 1'b1, MODE_SHR, 1'b1, 1'b0, 8'h00, 1'b0, '0);
    expect_const("shr_sr1", 8'hD2);

    step(MODE_LOAD, 8'h81);
    step(MODE_ROL, 8'h00);
    expect_const("rol_x1", 8'h03);
    step(MODE_LOAD, 8'h81);
    step(MODE_ROR, 8'h00);
    step(MODE_ROR, 8'h00);
    expect_const("ror_x2", 8'h60);
    step(MODE_LOAD, 8'h80);
    applyStimulus(1'b0, 1'b1, MODE_ASR, 1'b0, 1'b0, 8'h00, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, MODE_ASR, 1'b1, 1'b0, 8'h00, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, MODE_ASR, 1'b0, 1'b0, 8'h00, 1'b0, '0);
    expect_const("asr_x3", 8'hF0);
    step(MODE_LOAD, 8'h80);
    step(MODE_SHL, 8'h00);
    expect_const("shl_out", 8'h00);

    step(MODE_LOAD, 8'h01);
    applyStimulus(1'b0, 1'b1, MODE_SHL, 1'b0, 1'b0, 8'h00, 1'b1, 4'd5);
    step(MODE_HOLD, 8'h00);
    applyStimulus(1'b0, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hFF, 1'b1, 4'd3);
    step(MODE_HOLD, 8'h00);
    step(MODE_CLR, 8'h00);
    step(MODE_HOLD, 8'h00);
    expect_const("burst_shl5", 8'h20);
    applyStimulus(1'b0, 1'b1, MODE_HOLD, 1'b0, 1'b0, 8'h00, 1'b1, 4'd2);
    step(MODE_HOLD, 8'h00);

    applyStimulus(1'b0, 1'b1, MODE_CLR, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0);
    step(MODE_HOLD, 8'h00);
    step(MODE_HOLD, 8'h00);

    step(MODE_LOAD, 8'hB4);
    applyStimulus(1'b0, 1'b1, MODE_SHR, 1'b0, 1'b0, 8'h00, 1'b1, 4'd4);
    applyStimulus(1'b0, 1'b1, MODE_HOLD, 1'b1, 1'b0, 8'h00, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, MODE_HOLD, 1'b1, 1'b0, 8'h00, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, MODE_HOLD, 1'b1, 1'b0, 8'h00, 1'b0, '0);
    repeat (4) applyStimulus(1'b0, 1'b1, MODE_HOLD, 1'b0, 1'b0, 8'h00, 1'b0, '0);

    step(MODE_LOAD, 8'h3C);
    applyStimulus(1'b0, 1'b1, MODE_ROL, 1'b0, 1'b0, 8'h00, 1'b1, 4'd7);
    repeat (3) step(MODE_HOLD, 8'h00);
    applyStimulus(1'b1, 1'b1, MODE_HOLD, 1'b0, 1'b0, 8'h00, 1'b0, '0);
    step(MODE_LOAD, 8'h5A);
    applyStimulus(1'b0, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hC3, 1'b1, 4'd2);
    step(MODE_LOAD, 8'h11);
    step(MODE_HOLD, 8'h00);
    step(MODE_HOLD, 8'h00);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
                    3'($urandom), 1'($urandom), 1'($urandom), W'($urandom),
                    ($urandom_range(0, 9) == 0), CW'($urandom));
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge cp);
      guard++;
    end
    checkOutput("drain", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
